// File: rtl/axi4_lite_master_if.sv
// AXI4-Lite bus bundle (AW, W, B, AR, R) between one master and one register slave.
interface axi4_lite_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   AWADDR;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WVALID;
  logic                WREADY;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ADDR_W-1:0]   ARADDR;
  logic                ARVALID;
  logic                ARREADY;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RVALID;
  logic                RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI transaction, one response pulse out.
// Optional per-wait watchdog (rsp_resp=2'b11 on expiry) enabled by defining AXI_MASTER_TIMEOUT_EN.
module axi4_lite_master #(
  parameter int  ADDR_W         = 32,
  parameter int  DATA_W         = 32,
  parameter int  TIMEOUT_CYCLES = 256,
  localparam int STRB_W         = DATA_W / 8
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [STRB_W-1:0]   cmd_wstrb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  axi4_lite_master_if.master  axi
);

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD, RD_DATA, RESP} state_e;

  state_e              state_q, state_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_resp_q, rsp_resp_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                timeout_hit;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             waiting, any_hs;

  // Counter restarts on any handshake so a partially completed write gets a fresh window.
  always_comb begin
    waiting     = state_q inside {WR, WR_RESP, RD, RD_DATA};
    any_hs      = (awvalid_q && axi.AWREADY) || (wvalid_q && axi.WREADY) ||
                  (bready_q && axi.BVALID) || (arvalid_q && axi.ARREADY) ||
                  (rready_q && axi.RVALID);
    timeout_hit = waiting && !any_hs && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    cnt_d       = (!waiting || any_hs || (state_d != state_q)) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          if (cmd_we) begin
            state_d   = WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD;
            arvalid_d = 1'b1;
          end
        end
      end
      WR: begin
        if (awvalid_q && axi.AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && axi.WREADY)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (axi.BVALID && bready_q) begin
          rsp_resp_d  = axi.BRESP;
          rsp_rdata_d = '0;
          bready_d    = 1'b0;
          state_d     = RESP;
        end
      end
      RD: begin
        if (arvalid_q && axi.ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (axi.RVALID && rready_q) begin
          rsp_rdata_d = axi.RDATA;
          rsp_resp_d  = axi.RRESP;
          rready_d    = 1'b0;
          state_d     = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (timeout_hit) begin
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      bready_d    = 1'b0;
      arvalid_d   = 1'b0;
      rready_d    = 1'b0;
      rsp_resp_d  = 2'b11;
      rsp_rdata_d = '0;
      state_d     = RESP;
    end

    // Both flags are registered views of the next state, so they line up with state_q.
    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= IDLE;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
    end else begin
      state_q     <= state_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_resp    = rsp_resp_q;
  assign axi.AWADDR  = addr_q;
  assign axi.AWVALID = awvalid_q;
  assign axi.WDATA   = wdata_q;
  assign axi.WSTRB   = wstrb_q;
  assign axi.WVALID  = wvalid_q;
  assign axi.BREADY  = bready_q;
  assign axi.ARADDR  = addr_q;
  assign axi.ARVALID = arvalid_q;
  assign axi.RREADY  = rready_q;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Bench for axi4_lite_master: configurable-latency slave stub plus a word-memory reference model.
module tb_axi4_lite_master;
  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;

  always #5 ACLK = ~ACLK;

  axi4_lite_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  axi4_lite_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .axi(bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: expected memory contents, merged byte-wise by strobe.
  logic [31:0] mmem [logic [31:0]];
  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return mmem.exists(a) ? mmem[a] : 32'h0;
  endfunction
  function automatic void model_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w = model_rd(a);
    for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    mmem[a] = w;
  endfunction

  // Slave stub configuration
  int aw_dly = 1, w_dly = 1, b_dly = 1, ar_dly = 1, r_dly = 1;
  logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  bit spur = 0, to_mode = 0;
  logic [31:0] smem [logic [31:0]];

  initial begin : slave
    bit s_rst, s_awv, s_aw_hs, s_wv, s_w_hs, s_b_hs, s_arv, s_ar_hs, s_r_hs;
    bit aw_pend, w_pend, ar_pend, aw_hs_prev, w_hs_prev, ar_hs_prev;
    bit got_aw, got_w, b_busy, b_v, r_busy, r_v;
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic [31:0] s_awaddr, s_wdata, s_araddr, aw_a, w_d, ar_a, p_awaddr, p_wdata, p_araddr, wv;
    logic [3:0]  s_wstrb, w_s, p_wstrb;
    {aw_pend, w_pend, ar_pend, aw_hs_prev, w_hs_prev, ar_hs_prev} = '0;
    {got_aw, got_w, b_busy, b_v, r_busy, r_v} = '0;
    {aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt} = '0;
    {bus.AWREADY, bus.WREADY, bus.BVALID, bus.ARREADY, bus.RVALID} = '0;
    bus.BRESP = 2'b00; bus.RRESP = 2'b00; bus.RDATA = 32'h0;
    forever begin
      @(negedge ACLK);
      s_rst    = ARESET;
      s_awv    = bus.AWVALID; s_aw_hs = bus.AWVALID && bus.AWREADY; s_awaddr = bus.AWADDR;
      s_wv     = bus.WVALID;  s_w_hs  = bus.WVALID && bus.WREADY;
      s_wdata  = bus.WDATA;   s_wstrb = bus.WSTRB;
      s_b_hs   = bus.BVALID && bus.BREADY;
      s_arv    = bus.ARVALID; s_ar_hs = bus.ARVALID && bus.ARREADY; s_araddr = bus.ARADDR;
      s_r_hs   = bus.RVALID && bus.RREADY;
      if (!s_rst) begin
        if (aw_pend) chk("aw_hold", {bus.AWVALID, bus.AWADDR}, {1'b1, p_awaddr});
        if (w_pend)  chk("w_hold", {bus.WVALID, bus.WSTRB, bus.WDATA}, {1'b1, p_wstrb, p_wdata});
        if (ar_pend && !to_mode) chk("ar_hold", {bus.ARVALID, bus.ARADDR}, {1'b1, p_araddr});
        if (aw_hs_prev) chk("aw_drop", bus.AWVALID, 1'b0);
        if (w_hs_prev)  chk("w_drop", bus.WVALID, 1'b0);
        if (ar_hs_prev) chk("ar_drop", bus.ARVALID, 1'b0);
        if (b_busy) chk("bready_hold", bus.BREADY, 1'b1);
        if (r_busy) chk("rready_hold", bus.RREADY, 1'b1);
      end
      aw_pend = !s_rst && s_awv && !bus.AWREADY; p_awaddr = bus.AWADDR;
      w_pend  = !s_rst && s_wv && !bus.WREADY;   p_wdata = bus.WDATA; p_wstrb = bus.WSTRB;
      ar_pend = !s_rst && s_arv && !bus.ARREADY; p_araddr = bus.ARADDR;
      aw_hs_prev = s_aw_hs; w_hs_prev = s_w_hs; ar_hs_prev = s_ar_hs;
      @(posedge ACLK); #1;
      if (s_rst) begin
        {got_aw, got_w, b_busy, b_v, r_busy, r_v} = '0;
        {aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt} = '0;
        {bus.AWREADY, bus.WREADY, bus.ARREADY} = '0;
        bus.BRESP = 2'b00; bus.RRESP = 2'b00; bus.RDATA = 32'h0;
      end else begin
        if (s_aw_hs) begin bus.AWREADY = 0; got_aw = 1; aw_a = s_awaddr; aw_cnt = 0; end
        else if (s_awv) begin aw_cnt++; if (aw_cnt >= aw_dly) bus.AWREADY = 1; end
        if (s_w_hs) begin bus.WREADY = 0; got_w = 1; w_d = s_wdata; w_s = s_wstrb; w_cnt = 0; end
        else if (s_wv) begin w_cnt++; if (w_cnt >= w_dly) bus.WREADY = 1; end
        if (s_b_hs) begin b_v = 0; b_busy = 0; bus.BRESP = 2'b00; end
        if (got_aw && got_w) begin
          wv = smem.exists(aw_a) ? smem[aw_a] : 32'h0;
          for (int b = 0; b < 4; b++) if (w_s[b]) wv[8*b +: 8] = w_d[8*b +: 8];
          smem[aw_a] = wv;
          got_aw = 0; got_w = 0; b_busy = 1; b_cnt = 0;
        end
        if (b_busy && !b_v) begin
          b_cnt++;
          if (b_cnt >= b_dly) begin b_v = 1; bus.BRESP = bresp_cfg; end
        end
        if (s_r_hs) begin r_v = 0; r_busy = 0; bus.RDATA = 32'h0; bus.RRESP = 2'b00; end
        if (s_ar_hs) begin bus.ARREADY = 0; ar_cnt = 0; r_busy = 1; r_cnt = 0; ar_a = s_araddr; end
        else if (s_arv) begin ar_cnt++; if (ar_cnt >= ar_dly) bus.ARREADY = 1; end
        if (r_busy && !r_v) begin
          r_cnt++;
          if (r_cnt >= r_dly) begin
            r_v = 1;
            bus.RDATA = smem.exists(ar_a) ? smem[ar_a] : 32'h0;
            bus.RRESP = rresp_cfg;
          end
        end
      end
      bus.BVALID = b_v || spur;
      bus.RVALID = r_v || spur;
    end
  end

  // Presents a command and returns at #1 after the accepting edge.
  task automatic issue(input bit we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output int waited);
    cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
    waited = 0;
    while (cmd_ready !== 1'b1 && waited < 50) begin @(posedge ACLK); #1; waited++; end
    chk("accept_in_time", waited < 50, 1'b1);
    @(posedge ACLK); #1;
    cmd_valid = 1'b0;
  endtask

  // exp_lat = clock edges from the cycle after acceptance to the rsp_valid cycle; -1 skips it.
  task automatic wait_rsp(input int exp_lat, input logic [31:0] exp_d, input logic [1:0] exp_r);
    int k = 0;
    while (rsp_valid !== 1'b1 && k < 300) begin
      chk("busy_ready", cmd_ready, 1'b0);
      @(posedge ACLK); #1; k++;
    end
    chk("rsp_seen", rsp_valid, 1'b1);
    if (exp_lat >= 0) chk("rsp_latency", k, exp_lat);
    chk("rsp_rdata", rsp_rdata, exp_d);
    chk("rsp_resp", rsp_resp, exp_r);
    chk("resp_ready", cmd_ready, 1'b0);
    @(posedge ACLK); #1;
    chk("rsp_width", rsp_valid, 1'b0);
    chk("idle_ready", cmd_ready, 1'b1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int w, lat;
    bit we;
    logic [31:0] a, d;
    logic [3:0] s;
    ARESET = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    smem[32'h4] = 32'hDEADBEEF; mmem[32'h4] = 32'hDEADBEEF;
    repeat (3) @(posedge ACLK);
    #1;
    chk("reset_ctrl", {cmd_ready, rsp_valid, bus.AWVALID, bus.WVALID, bus.BREADY,
                       bus.ARVALID, bus.RREADY}, 7'b0);
    chk("reset_rsp", {rsp_rdata, rsp_resp}, 34'h0);
    chk("reset_aw_ar", {bus.AWADDR, bus.ARADDR}, 64'h0);
    chk("reset_w", {bus.WSTRB, bus.WDATA}, 36'h0);
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    chk("ready_after_reset", cmd_ready, 1'b1);

    // Basic write then read-back
    issue(1, 32'h0, 32'hCAFEF00D, 4'hF, w);
    wait_rsp(3, 32'h0, 2'b00); model_wr(32'h0, 32'hCAFEF00D, 4'hF);
    issue(0, 32'h0, 32'h0, 4'h0, w);
    wait_rsp(3, model_rd(32'h0), 2'b00);
    issue(0, 32'h4, 32'h0, 4'h0, w);
    wait_rsp(3, 32'hDEADBEEF, 2'b00);

    // WREADY much later than AWREADY, partial strobes
    w_dly = 4;
    issue(1, 32'h8, 32'h12345678, 4'b0011, w);
    wait_rsp(6, 32'h0, 2'b00); model_wr(32'h8, 32'h12345678, 4'b0011);
    w_dly = 1;
    issue(0, 32'h8, 32'h0, 4'h0, w);
    wait_rsp(3, 32'h00005678, 2'b00);

    // Late B/R with SLVERR
    b_dly = 4; r_dly = 4; bresp_cfg = 2'b10; rresp_cfg = 2'b10;
    issue(1, 32'hC, 32'h00000001, 4'hF, w);
    wait_rsp(6, 32'h0, 2'b10); model_wr(32'hC, 32'h1, 4'hF);
    issue(0, 32'hC, 32'h0, 4'h0, w);
    wait_rsp(6, 32'h00000001, 2'b10);
    b_dly = 1; r_dly = 1; bresp_cfg = 2'b00; rresp_cfg = 2'b00;

    // Reset one cycle after a write is accepted
    issue(1, 32'h10, 32'hAAAA5555, 4'hF, w);
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    chk("abort_outputs", {cmd_ready, rsp_valid, bus.AWVALID, bus.WVALID, bus.BREADY,
                          bus.ARVALID, bus.RREADY}, 7'b0);
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    chk("abort_ready", cmd_ready, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("abort_quiet", {rsp_valid, bus.AWVALID, bus.WVALID}, 3'b0);
      @(posedge ACLK); #1;
    end
    issue(0, 32'h10, 32'h0, 4'h0, w);
    wait_rsp(3, model_rd(32'h10), 2'b00);

    // Back-to-back: second command held through the first one's response
    issue(1, 32'h20, 32'h0BADC0DE, 4'hF, w);
    cmd_we = 1'b0; cmd_addr = 32'h20; cmd_valid = 1'b1;
    wait_rsp(3, 32'h0, 2'b00); model_wr(32'h20, 32'h0BADC0DE, 4'hF);
    issue(0, 32'h20, 32'h0, 4'h0, w);
    chk("b2b_wait", w, 0);
    wait_rsp(3, model_rd(32'h20), 2'b00);

    // Stray B/R valids while idle
    spur = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge ACLK); #1;
      chk("spur_idle", {cmd_ready, rsp_valid, bus.BREADY, bus.RREADY}, 4'b1000);
    end
    spur = 0;
    repeat (2) @(posedge ACLK);
    #1;

`ifdef AXI_MASTER_TIMEOUT_EN
    to_mode = 1; ar_dly = 1000;
    issue(0, 32'h4, 32'h0, 4'h0, w);
    wait_rsp(8, 32'h0, 2'b11);
    chk("timeout_ar_low", bus.ARVALID, 1'b0);
    to_mode = 0; ar_dly = 1;
`else
    ar_dly = 1000;
    issue(0, 32'h4, 32'h0, 4'h0, w);
    repeat (20) @(posedge ACLK);
    #1;
    chk("ar_waits", {bus.ARVALID, rsp_valid, cmd_ready}, 3'b100);
    ar_dly = 1;
    wait_rsp(-1, 32'hDEADBEEF, 2'b00);
`endif

    // Randomized traffic against the memory model
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 15) * 4);
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      aw_dly = $urandom_range(1, 3); w_dly = $urandom_range(1, 3); b_dly = $urandom_range(1, 3);
      ar_dly = $urandom_range(1, 3); r_dly = $urandom_range(1, 3);
      bresp_cfg = 2'($urandom_range(0, 3)); rresp_cfg = 2'($urandom_range(0, 3));
      if (we) lat = 1 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly;
      else    lat = 1 + ar_dly + r_dly;
      issue(we, a, d, s, w);
      if (we) begin
        wait_rsp(lat, 32'h0, bresp_cfg);
        model_wr(a, d, s);
      end else begin
        wait_rsp(lat, model_rd(a), rresp_cfg);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/axi4_lite_master.md
Name: axi4_lite_master

Overview:
Single-outstanding AXI4-Lite master that turns a simple command/response request port into AXI4-Lite write and read transactions. It sits directly upstream of the register-slave block and drives all five AXI4-Lite channels. One transaction is in flight at a time, and each command produces exactly one response.

Parameters:
ADDR_W, 32, AXI address width
DATA_W, 32, AXI data width (STRB width = DATA_W/8)
TIMEOUT_CYCLES, 256, watchdog limit per channel wait (used only with the optional feature)

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESET  in  1  synchronous reset, active-high
cmd_valid  in  1  request valid
cmd_ready  out  1  request accepted when cmd_valid && cmd_ready
cmd_we  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  transaction address
cmd_wdata  in  DATA_W  write data
cmd_wstrb  in  DATA_W/8  write byte strobes
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_W  read data (0 for writes)
rsp_resp  out  2  BRESP/RRESP copy (2'b11 = timeout, optional feature only)
AWADDR  out  ADDR_W ; AWVALID  out  1 ; AWREADY  in  1
WDATA  out  DATA_W ; WSTRB  out  DATA_W/8 ; WVALID  out  1 ; WREADY  in  1
BRESP  in  2 ; BVALID  in  1 ; BREADY  out  1
ARADDR  out  ADDR_W ; ARVALID  out  1 ; ARREADY  in  1
RDATA  in  DATA_W ; RRESP  in  2 ; RVALID  in  1 ; RREADY  out  1

Behaviour:
- Interface is fixed: one clock ACLK; reset ARESET is synchronous and active-high.
- Reset values: all VALID/READY outputs 0; cmd_ready 0 in the reset cycle, then 1 in IDLE; rsp_valid 0; rsp_rdata 0; rsp_resp 0; AWADDR/WDATA/WSTRB/ARADDR 0; state IDLE.
- ARESET mid-transaction: abandon immediately, no rsp_valid, all outputs to reset values next edge.
- FSM states: IDLE, WR, WR_RESP, RD, RD_DATA, RESP.
- IDLE: cmd_ready=1. On accept, register addr/wdata/wstrb.
  - cmd_we=1: next state WR, AWVALID=WVALID=1 from the next cycle.
  - cmd_we=0: next state RD, ARVALID=1 from the next cycle.
- WR: AWVALID and WVALID tracked independently.
  - Each VALID deasserts the cycle after its own handshake (xVALID && xREADY).
  - Payload stable while VALID is high.
  - Leave WR once both handshakes are done, including when they occur in the same cycle (the common case with the slave). Go to WR_RESP with BREADY=1.
- WR_RESP: on BVALID && BREADY, capture BRESP, set rsp_rdata=0, drop BREADY, go to RESP.
- RD: hold ARVALID until ARVALID && ARREADY, then drop it, set RREADY=1, go to RD_DATA.
- RD_DATA: on RVALID && RREADY, capture RDATA and RRESP, drop RREADY, go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. No backpressure on the response port.
- cmd_ready=0 outside IDLE; cmd_valid is ignored there.
- BVALID/RVALID arriving outside WR_RESP/RD_DATA: ignored, no state change.
- Latency against the slave (AW/W/ARREADY one cycle after VALID; B/R one cycle after that):
  - Write: accept at cycle T, AW/W handshake at T+2, B handshake at T+3, rsp_valid at T+4.
  - Read: identical timing.
- Master never asserts VALID combinationally from READY. All outputs are registered.

Optional Feature:
AXI_MASTER_TIMEOUT_EN
- Defined: a counter runs in WR, WR_RESP, RD and RD_DATA.
  - Counter resets on every handshake and on state entry.
  - Reaching TIMEOUT_CYCLES with the awaited handshake still missing: drop all VALID/READY outputs, go to RESP with rsp_resp=2'b11, rsp_rdata=0.
- Not defined: no counter; the master waits indefinitely. rsp_resp only carries the slave value.

Test Plan:
- Write 0xCAFEF00D, strb 4'hF, addr 0x00 -> AW/W handshake at T+2, BREADY high until B, rsp_valid at T+4 with rsp_resp=00. A following read of 0x00 returns rsp_rdata=0xCAFEF00D.
- Read addr 0x04 from the slave -> ARVALID held until ARREADY; rsp_rdata=0xDEADBEEF, rsp_resp=00, rsp_valid width exactly 1 cycle.
- Stub slave gives AWREADY at +1 and WREADY at +4 -> AWVALID drops after its handshake; WVALID held with stable WDATA until cycle +4; exactly one rsp_valid.
- Stub slave holds BVALID/RVALID 3 cycles late with BRESP=10 -> BREADY/RREADY held the whole time; rsp_resp=10.
- ARESET asserted one cycle after a write is accepted -> AWVALID/WVALID 0 next edge, no rsp_valid, cmd_ready=1 the cycle after reset releases. A back-to-back cmd_valid held through RESP is accepted only in IDLE.
- With AXI_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=8, ARREADY tied 0 -> ARVALID drops after 8 cycles, rsp_valid with rsp_resp=11, rsp_rdata=0.
